hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage 8-bit pipeline (F, D, E, M, W).
- Drives stall/flush of every pipeline register, including FlushE of the D→E register.
- Selects operand forwarding for E, inserts load-use bubbles, freezes the pipe during multi-cycle data-memory accesses, and flushes wrong-path instructions on taken branches.
- Keeps a wait FSM, a timeout detector and a stall-cycle performance counter.

Parameters:
- MAX_WAIT, 15: memory-wait cycles tolerated before MemTimeout sets.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk in 1: clock, rising edge.
- reset in 1: synchronous, active-high.
- RA1D, RA2D in 3 each: source registers in D.
- RA1E, RA2E in 3 each: source registers in E.
- WA3E, WA4E in 3 each: write-port A/B destinations in E.
- RegWriteAE, RegWriteBE in 1 each: write enables in E.
- MemtoRegE in 1: E instruction is a load (port A).
- WA3M, WA4M, RegWriteAM, RegWriteBM in 3/3/1/1: M-stage destinations and enables.
- MemtoRegM in 1: M instruction is a load.
- MemReadyM in 1: data memory done this cycle.
- WA3W, WA4W, RegWriteAW, RegWriteBW in 3/3/1/1: W-stage destinations and enables.
- BranchTakenE in 1: taken branch resolved in E.
- StallF, StallD, StallE, StallM out 1 each: hold the corresponding pipeline register.
- FlushD, FlushE, FlushW out 1 each: load NOP (all-zero) into the corresponding register.
- FwdAE, FwdBE out 3 each: operand mux selects for E.
- MemTimeout out 1: sticky error flag.
- StallCount out CNT_W: saturating count of stalled cycles.

Behaviour:
- Forward select encoding:
  - 0: register-file value.
  - 1: M port A result.
  - 2: M port B result.
  - 3: W port A result.
  - 4: W port B result.
- Forwarding for RA1E (same rules for RA2E → FwdBE):
  - Each candidate matches only when its enable is set and its address equals the source.
  - Priority: M over W; within a stage, port A over port B.
  - No hard-wired zero register; all 8 registers forward.
  - Forwarding is purely combinational from the current-cycle inputs.
- lduse = MemtoRegE & RegWriteAE & (WA3E==RA1D | WA3E==RA2D).
- memwait = MemtoRegM & !MemReadyM.
- FSM states: RUN, WAIT.
  - RUN→WAIT when memwait.
  - WAIT→RUN when MemReadyM.
  - Any state→RUN on reset.
- Output priority, highest first (combinational from state and inputs):
  1. memwait (in RUN or WAIT): StallF, StallD, StallE, StallM=1; FlushW=1; all other flushes 0. A taken branch in E stays frozen and is acted on after release.
  2. BranchTakenE: FlushD=1, FlushE=1, no stalls. The load-use check is suppressed because the D instruction is discarded.
  3. lduse: StallF=1, StallD=1, FlushE=1 for exactly one cycle. The next cycle sees MemtoRegE=0 (bubble), so the stall does not repeat.
  4. Otherwise: all stall/flush outputs 0.
- The cycle MemReadyM=1 arrives, memwait is 0. The freeze releases in that same cycle, so the load result is captured by W.
- Wait counter:
  - Cleared on entering WAIT; increments each WAIT cycle with memwait; saturates at MAX_WAIT.
  - A memwait cycle with counter==MAX_WAIT sets MemTimeout.
  - MemTimeout clears only on reset. It does not alter stalling: the pipe keeps waiting.
- StallCount increments (saturating at all-ones) on every cycle where StallF=1.
- Reset (synchronous):
  - Registered state: state=RUN, wait counter=0, MemTimeout=0, StallCount=0.
  - Outputs while reset=1: all stalls 0, FlushD=FlushE=FlushW=1 (pipe drains to NOPs), FwdAE=FwdBE=0.
  - Reset mid-WAIT aborts the wait with no residual stall on the next cycle.
- Latency: all control outputs act in the same cycle; only the FSM, counters and flags are registered.

Decomposition:
- Shared package hazard_pkg:
  - Typedef fwd_sel_t (3-bit enum FWD_RF, FWD_MA, FWD_MB, FWD_WA, FWD_WB).
  - Typedef hz_state_t (RUN, WAIT).
  - Register-address width constant (3).
- One sub-module, fwd_sel: pure-combinational per-operand forwarding priority. Instantiated twice, for operands A and B.

Test Plan:
- Forward priority: RA1E=3, WA3M=3, RegWriteAM=1, WA3W=3, RegWriteAW=1 → FwdAE=1. Drop RegWriteAM → FwdAE=3. Then set WA4W=3, RegWriteBW=1 and drop RegWriteAW → FwdAE=4.
- Load-use: MemtoRegE=1, RegWriteAE=1, WA3E=5, RA2D=5 → one cycle of StallF=StallD=FlushE=1. The next cycle (bubble in E) → all stall/flush outputs 0. StallCount=1.
- Memory wait: MemtoRegM=1, MemReadyM low for 4 cycles then high → 4 cycles of StallF/D/E/M=1 with FlushW=1. Released on the ready cycle. StallCount=4. MemTimeout=0.
- Timeout: with MAX_WAIT=15, hold MemReadyM low for 20 cycles → MemTimeout rises when the counter is 15 and stays high after ready. StallCount keeps counting throughout.
- Branch vs hazards: BranchTakenE=1 together with lduse → FlushD=FlushE=1, StallF=0. BranchTakenE=1 together with memwait → freeze only; flushes occur on the ready cycle.
- Reset mid-WAIT after 3 wait cycles → during reset FlushD/E/W=1 and stalls 0. Afterwards state=RUN, counters 0, MemTimeout=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the 5-stage pipeline hazard
// controller.
//   REG_AW     : register-address width (8 architectural registers).
//   fwd_sel_t  : operand-forwarding mux select used in E.
//   hz_state_t : memory-wait FSM state.
package hazard_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    FWD_RF = 3'd0,
    FWD_MA = 3'd1,
    FWD_MB = 3'd2,
    FWD_WA = 3'd3,
    FWD_WB = 3'd4
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding-priority selector for one E-stage source operand.
// Purely combinational.
//   ra                  : source register read in E.
//   wa3_m/wa4_m         : M-stage port A/B destinations.
//   reg_write_a_m/_b_m  : M-stage port A/B write enables.
//   wa3_w/wa4_w         : W-stage port A/B destinations.
//   reg_write_a_w/_b_w  : W-stage port A/B write enables.
//   sel                 : operand mux select.
// The youngest producer wins (M over W); within a stage port A beats port B.
// Register 0 is an ordinary register and forwards like the others.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] wa3_m,
  input  logic [REG_AW-1:0] wa4_m,
  input  logic              reg_write_a_m,
  input  logic              reg_write_b_m,
  input  logic [REG_AW-1:0] wa3_w,
  input  logic [REG_AW-1:0] wa4_w,
  input  logic              reg_write_a_w,
  input  logic              reg_write_b_w,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_a_m && (wa3_m == ra)) begin
      sel = FWD_MA;
    end else if (reg_write_b_m && (wa4_m == ra)) begin
      sel = FWD_MB;
    end else if (reg_write_a_w && (wa3_w == ra)) begin
      sel = FWD_WA;
    end else if (reg_write_b_w && (wa4_w == ra)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard controller for the F/D/E/M/W pipeline.
//   clk, reset                 : clock and synchronous active-high reset.
//   RA1D/RA2D                  : D-stage sources (load-use detection).
//   RA1E/RA2E                  : E-stage sources (forwarding).
//   WA3E/WA4E, RegWriteAE/BE   : E-stage destinations/enables.
//   MemtoRegE                  : E instruction is a load on port A.
//   WA3M/WA4M, RegWriteAM/BM   : M-stage destinations/enables.
//   MemtoRegM, MemReadyM       : M load in flight / memory done this cycle.
//   WA3W/WA4W, RegWriteAW/BW   : W-stage destinations/enables.
//   BranchTakenE               : taken branch resolved in E.
//   StallF/D/E/M               : hold the pipeline registers.
//   FlushD/E/W                 : load a NOP into the pipeline registers.
//   FwdAE/FwdBE                : E operand forwarding selects.
//   MemTimeout                 : sticky, set when a wait exceeds MAX_WAIT.
//   StallCount                 : saturating count of cycles with StallF=1.
// All stall/flush/forward outputs are combinational; only the wait FSM, the
// wait counter, MemTimeout and StallCount are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA4E,
  input  logic              RegWriteAE,
  input  logic              RegWriteBE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA4M,
  input  logic              RegWriteAM,
  input  logic              RegWriteBM,
  input  logic              MemtoRegM,
  input  logic              MemReadyM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic [REG_AW-1:0] WA4W,
  input  logic              RegWriteAW,
  input  logic              RegWriteBW,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [2:0]        FwdAE,
  output logic [2:0]        FwdBE,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned         WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0]   WAIT_MAX = WCNT_W'(MAX_WAIT);

  hz_state_t         state;
  hz_state_t         next_state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              memwait;
  logic              lduse;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;

  // Loads only write through port A, so the E-stage port B destination can
  // never create a load-use hazard.
  logic unused_e_port_b;
  assign unused_e_port_b = ^{WA4E, RegWriteBE};

  assign memwait = MemtoRegM && !MemReadyM;
  assign lduse   = MemtoRegE && RegWriteAE && ((WA3E == RA1D) || (WA3E == RA2D));

  fwd_sel u_fwd_a (
    .ra            (RA1E),
    .wa3_m         (WA3M),
    .wa4_m         (WA4M),
    .reg_write_a_m (RegWriteAM),
    .reg_write_b_m (RegWriteBM),
    .wa3_w         (WA3W),
    .wa4_w         (WA4W),
    .reg_write_a_w (RegWriteAW),
    .reg_write_b_w (RegWriteBW),
    .sel           (fwd_a)
  );

  fwd_sel u_fwd_b (
    .ra            (RA2E),
    .wa3_m         (WA3M),
    .wa4_m         (WA4M),
    .reg_write_a_m (RegWriteAM),
    .reg_write_b_m (RegWriteBM),
    .wa3_w         (WA3W),
    .wa4_w         (WA4W),
    .reg_write_a_w (RegWriteAW),
    .reg_write_b_w (RegWriteBW),
    .sel           (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Outputs depend only on current inputs; the FSM state merely tracks the
  // wait episode for the timeout counter.
  always_comb begin
    next_state = state;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    FwdAE      = fwd_a;
    FwdBE      = fwd_b;

    case (state)
      RUN:     if (memwait)   next_state = WAIT;
      WAIT:    if (MemReadyM) next_state = RUN;
      default: next_state = RUN;
    endcase

    if (reset) begin
      // Drain every stage to NOPs while in reset.
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
      FwdAE  = FWD_RF;
      FwdBE  = FWD_RF;
    end else if (memwait) begin
      // Freeze F..M; W takes bubbles until the load data arrives. A taken
      // branch in E is held and acted on in the release cycle.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTakenE) begin
      // D holds a wrong-path instruction, so its load-use hazard is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lduse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Wait counter is zero whenever the FSM sits in RUN, so every wait
  // episode starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else if ((state == RUN) || MemReadyM) begin
      wait_cnt <= '0;
    end else if (memwait) begin
      if (wait_cnt == WAIT_MAX) begin
        MemTimeout <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. The driver applies
// directed then random stimulus, predicts each cycle's outputs with a
// behavioural model and queues them; a monitor compares on the falling edge.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;
  localparam int SC_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic       reset;
    logic [2:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa4e;
    logic       rwae, rwbe, mtre;
    logic [2:0] wa3m, wa4m;
    logic       rwam, rwbm, mtrm, rdym;
    logic [2:0] wa3w, wa4w;
    logic       rwaw, rwbw, br;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       sf, sd, se, sm, fd, fe, fw;
    logic [2:0] fa, fb;
    logic       to;
    int         sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA4E, WA3M, WA4M, WA3W, WA4W;
  logic RegWriteAE, RegWriteBE, MemtoRegE, RegWriteAM, RegWriteBM;
  logic MemtoRegM, MemReadyM, RegWriteAW, RegWriteBW, BranchTakenE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [2:0] FwdAE, FwdBE;
  logic MemTimeout;
  logic [CNT_W-1:0] StallCount;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA4E(WA4E), .RegWriteAE(RegWriteAE), .RegWriteBE(RegWriteBE),
    .MemtoRegE(MemtoRegE),
    .WA3M(WA3M), .WA4M(WA4M), .RegWriteAM(RegWriteAM), .RegWriteBM(RegWriteBM),
    .MemtoRegM(MemtoRegM), .MemReadyM(MemReadyM),
    .WA3W(WA3W), .WA4W(WA4W), .RegWriteAW(RegWriteAW), .RegWriteBW(RegWriteBW),
    .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .FwdAE(FwdAE), .FwdBE(FwdBE),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference state: is a memory wait in progress, how many wait cycles it
  // has counted, the sticky timeout and the stall tally.
  bit m_waiting = 1'b0;
  int m_waited  = 0;
  bit m_to      = 1'b0;
  int m_sc      = 0;

  function automatic logic [2:0] fwd_model(input stim_t s, input logic [2:0] ra);
    logic       en  [4];
    logic [2:0] wa  [4];
    en[0] = s.rwam; wa[0] = s.wa3m;
    en[1] = s.rwbm; wa[1] = s.wa4m;
    en[2] = s.rwaw; wa[2] = s.wa3w;
    en[3] = s.rwbw; wa[3] = s.wa4w;
    for (int k = 0; k < 4; k++) begin
      if (en[k] && wa[k] == ra) return 3'(k + 1);
    end
    return 3'd0;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   memwait, lduse;
    reset = s.reset; RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA4E = s.wa4e; RegWriteAE = s.rwae; RegWriteBE = s.rwbe;
    MemtoRegE = s.mtre; WA3M = s.wa3m; WA4M = s.wa4m; RegWriteAM = s.rwam;
    RegWriteBM = s.rwbm; MemtoRegM = s.mtrm; MemReadyM = s.rdym;
    WA3W = s.wa3w; WA4W = s.wa4w; RegWriteAW = s.rwaw; RegWriteBW = s.rwbw;
    BranchTakenE = s.br;

    memwait = s.mtrm && !s.rdym;
    lduse   = s.mtre && s.rwae && (s.wa3e == s.ra1d || s.wa3e == s.ra2d);
    e = '{cyc: cyc, sf: 0, sd: 0, se: 0, sm: 0, fd: 0, fe: 0, fw: 0,
          fa: 0, fb: 0, to: m_to, sc: m_sc};
    if (s.reset) begin
      e.fd = 1; e.fe = 1; e.fw = 1;
    end else begin
      e.fa = fwd_model(s, s.ra1e);
      e.fb = fwd_model(s, s.ra2e);
      if (memwait) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      end else if (s.br) begin
        e.fd = 1; e.fe = 1;
      end else if (lduse) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
    end
    sb.push_back(e);

    if (s.reset) begin
      m_waiting = 0; m_waited = 0; m_to = 0; m_sc = 0;
    end else begin
      if (e.sf && m_sc < SC_MAX) m_sc++;
      if (!m_waiting) begin
        if (memwait) begin m_waiting = 1; m_waited = 0; end
      end else if (s.rdym) begin
        m_waiting = 0; m_waited = 0;
      end else if (memwait) begin
        if (m_waited >= MAX_WAIT) m_to = 1;
        else m_waited++;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int c, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("StallF", e.cyc, longint'(StallF), longint'(e.sf));
        chk("StallD", e.cyc, longint'(StallD), longint'(e.sd));
        chk("StallE", e.cyc, longint'(StallE), longint'(e.se));
        chk("StallM", e.cyc, longint'(StallM), longint'(e.sm));
        chk("FlushD", e.cyc, longint'(FlushD), longint'(e.fd));
        chk("FlushE", e.cyc, longint'(FlushE), longint'(e.fe));
        chk("FlushW", e.cyc, longint'(FlushW), longint'(e.fw));
        chk("FwdAE", e.cyc, longint'(FwdAE), longint'(e.fa));
        chk("FwdBE", e.cyc, longint'(FwdBE), longint'(e.fb));
        chk("MemTimeout", e.cyc, longint'(MemTimeout), longint'(e.to));
        chk("StallCount", e.cyc, longint'(StallCount), longint'(e.sc));
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 0, ra1d: 0, ra2d: 1, ra1e: 2, ra2e: 3, wa3e: 0, wa4e: 0,
          rwae: 0, rwbe: 0, mtre: 0, wa3m: 0, wa4m: 0, rwam: 0, rwbm: 0,
          mtrm: 0, rdym: 1, wa3w: 0, wa4w: 0, rwaw: 0, rwbw: 0, br: 0};
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    int    wait_left;
    int    drain;
    s = idle();
    s.reset = 1;
    reset = 1'b1;
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA4E = 0;
    RegWriteAE = 0; RegWriteBE = 0; MemtoRegE = 0; WA3M = 0; WA4M = 0;
    RegWriteAM = 0; RegWriteBM = 0; MemtoRegM = 0; MemReadyM = 1;
    WA3W = 0; WA4W = 0; RegWriteAW = 0; RegWriteBW = 0; BranchTakenE = 0;
    repeat (2) @(posedge clk);
    #1;
    step(s);                       // reset state with registers known

    // Forwarding priority
    s = idle();
    s.ra1e = 3; s.wa3m = 3; s.rwam = 1; s.wa3w = 3; s.rwaw = 1;
    step(s);
    s.rwam = 0;
    step(s);
    s.wa4w = 3; s.rwbw = 1; s.rwaw = 0;
    step(s);

    // Load-use bubble
    s = idle();
    s.mtre = 1; s.rwae = 1; s.wa3e = 5; s.ra2d = 5;
    step(s);
    s.mtre = 0;
    step(s);

    // Short memory wait
    s = idle();
    s.mtrm = 1; s.rdym = 0;
    repeat (4) step(s);
    s.rdym = 1;
    step(s);
    step(idle());

    // Long wait: timeout
    s = idle();
    s.mtrm = 1; s.rdym = 0;
    repeat (20) step(s);
    s.rdym = 1;
    step(s);
    repeat (2) step(idle());

    // Branch versus load-use and memory wait
    s = idle();
    s.mtre = 1; s.rwae = 1; s.wa3e = 4; s.ra1d = 4; s.br = 1;
    step(s);
    s = idle();
    s.br = 1; s.mtrm = 1; s.rdym = 0;
    repeat (2) step(s);
    s.rdym = 1;
    step(s);
    step(idle());

    // Reset in the middle of a wait
    s = idle();
    s.mtrm = 1; s.rdym = 0;
    repeat (4) step(s);
    s.reset = 1;
    step(s);
    repeat (2) step(idle());

    // Random traffic
    wait_left = -1;
    for (int n = 0; n < 3000; n++) begin
      s.reset = ($urandom_range(0, 299) == 0);
      s.ra1d = 3'($urandom); s.ra2d = 3'($urandom);
      s.ra1e = 3'($urandom); s.ra2e = 3'($urandom);
      s.wa3e = 3'($urandom); s.wa4e = 3'($urandom);
      s.wa3m = 3'($urandom); s.wa4m = 3'($urandom);
      s.wa3w = 3'($urandom); s.wa4w = 3'($urandom);
      s.rwae = 1'($urandom); s.rwbe = 1'($urandom);
      s.rwam = 1'($urandom); s.rwbm = 1'($urandom);
      s.rwaw = 1'($urandom); s.rwbw = 1'($urandom);
      s.mtre = ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      if (wait_left < 0 && $urandom_range(0, 7) == 0)
        wait_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 25))
                                                : int'($urandom_range(1, 5));
      if (wait_left > 0) begin
        s.mtrm = 1; s.rdym = 0; wait_left--;
      end else if (wait_left == 0) begin
        s.mtrm = 1; s.rdym = 1; wait_left = -1;
      end else begin
        s.mtrm = ($urandom_range(0, 3) == 0); s.rdym = 1;
      end
      step(s);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
